// File: rtl/mem_if_pkg.sv
// Shared definitions for the toggle-strobe main-memory burst interface.
// Used by both the memory side (main_memory_burst) and the L2 side.
//   ADDR_WIDTH / DATA_WIDTH / BURST_LENGTH : bus geometry
//   mem_state_e                            : memory controller FSM states
//   beat_idx_t                             : beat index within one 8-beat line
package mem_if_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 64;
    localparam int unsigned BURST_LENGTH = 8;

    typedef logic [2:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BURST_LENGTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StBurstRd,
        StBurstWr,
        StDone
    } mem_state_e;

    // Critical-word-first ordering: the 3-bit add wraps inside the line.
    function automatic beat_idx_t wrap_beat(input beat_idx_t start, input beat_idx_t k);
        return start + k;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM backing store, one read or write per cycle.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata, 0 = read into rdata
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid one cycle after a read access, held otherwise
// Contents are never reset.
module mem_array #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/main_memory_burst.sv
// Main-memory model/controller below the L2 cache. Services 8-beat x 64-bit line fills
// (we_MEM=1) and write-backs (we_MEM=0) on the toggle-strobe protocol.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   addrstb_MEM : request strobe, every level change is one request
//   we_MEM      : 1 = read burst, 0 = write burst, sampled with the address
//   addr_MEM    : byte address, sampled when the toggle is detected
//   data_MEM    : burst data, driven by memory only during read beats
//   stb         : beat strobe, toggles once per beat
//   busy        : burst in progress or request pending
//   proto_err   : sticky, a request arrived while the pending slot was full
module main_memory_burst
    import mem_if_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  addrstb_MEM,
    input  logic                  we_MEM,
    input  logic [ADDR_WIDTH-1:0] addr_MEM,
    inout  wire  [DATA_WIDTH-1:0] data_MEM,
    output logic                  stb,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(LATENCY - 1);

    mem_state_e state_q, state_d;

    logic                      addrstb_q;
    logic [MEM_DEPTH_LOG2-1:0] cur_idx_q, cur_idx_d;
    logic                      cur_rd_q, cur_rd_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [MEM_DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;
    logic                      pend_rd_q, pend_rd_d;
    logic [LatW-1:0]           lat_cnt_q, lat_cnt_d;
    beat_idx_t                 beat_q, beat_d;
    // High in the cycle the RAM is accessed; stb toggles on the edge that ends it.
    logic                      access_q, access_d;
    logic                      stb_q, stb_d;
    logic                      drive_q, drive_d;
    logic                      perr_q, perr_d;

    logic                      req;
    logic [MEM_DEPTH_LOG2-1:0] req_idx;
    logic                      ram_en;
    logic                      ram_we;
    logic [MEM_DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_rdata;
    logic                      unused_addr;

    assign req         = addrstb_MEM ^ addrstb_q;
    assign req_idx     = addr_MEM[MEM_DEPTH_LOG2+2:3];
    // High address bits alias; byte offset within a word is irrelevant.
    assign unused_addr = ^{addr_MEM[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], addr_MEM[2:0]};

    assign ram_en   = access_q && (state_q == StBurstRd || state_q == StBurstWr);
    assign ram_we   = (state_q == StBurstWr);
    assign ram_addr = {cur_idx_q[MEM_DEPTH_LOG2-1:3],
                       wrap_beat(beat_idx_t'(cur_idx_q[2:0]), beat_q)};

    mem_array #(
        .DEPTH_LOG2(MEM_DEPTH_LOG2),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(data_MEM),
        .rdata(ram_rdata)
    );

    // RAM output register holds the beat until the next read, so it doubles as bus data.
    assign data_MEM  = drive_q ? ram_rdata : {DATA_WIDTH{1'bz}};
    assign stb       = stb_q;
    assign busy      = (state_q != StIdle) || pend_valid_q;
    assign proto_err = perr_q;

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        cur_rd_d     = cur_rd_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        pend_rd_d    = pend_rd_q;
        lat_cnt_d    = lat_cnt_q;
        beat_d       = beat_q;
        access_d     = access_q;
        stb_d        = stb_q;
        drive_d      = drive_q;
        perr_d       = perr_q;

        // Requests arriving mid-transaction go to the one-deep slot.
        if (req && state_q != StIdle && state_q != StDone) begin
            if (pend_valid_q) begin
                perr_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_idx_d   = req_idx;
                pend_rd_d    = we_MEM;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d   = StWait;
                    cur_idx_d = req_idx;
                    cur_rd_d  = we_MEM;
                    lat_cnt_d = '0;
                end
            end
            StWait: begin
                if (lat_cnt_q == LatLast) begin
                    state_d  = cur_rd_q ? StBurstRd : StBurstWr;
                    beat_d   = '0;
                    access_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StBurstRd, StBurstWr: begin
                if (access_q) begin
                    stb_d = ~stb_q;
                    if (state_q == StBurstRd) begin
                        drive_d = 1'b1;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_d   = beat_q + beat_idx_t'(1);
                        access_d = 1'b0;
                    end
                end else begin
                    access_d = 1'b1;
                end
            end
            StDone: begin
                drive_d = 1'b0;
                if (pend_valid_q) begin
                    // Slot drains this cycle, so a simultaneous request refills it.
                    state_d      = StWait;
                    cur_idx_d    = pend_idx_q;
                    cur_rd_d     = pend_rd_q;
                    lat_cnt_d    = '0;
                    pend_valid_d = req;
                    pend_idx_d   = req_idx;
                    pend_rd_d    = we_MEM;
                end else if (req) begin
                    state_d   = StWait;
                    cur_idx_d = req_idx;
                    cur_rd_d  = we_MEM;
                    lat_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addrstb_q    <= 1'b0;
            cur_idx_q    <= '0;
            cur_rd_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_rd_q    <= 1'b0;
            lat_cnt_q    <= '0;
            beat_q       <= '0;
            access_q     <= 1'b0;
            stb_q        <= 1'b0;
            drive_q      <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addrstb_q    <= addrstb_MEM;
            cur_idx_q    <= cur_idx_d;
            cur_rd_q     <= cur_rd_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            pend_rd_q    <= pend_rd_d;
            lat_cnt_q    <= lat_cnt_d;
            beat_q       <= beat_d;
            access_q     <= access_d;
            stb_q        <= stb_d;
            drive_q      <= drive_d;
            perr_q       <= perr_d;
        end
    end

endmodule

// File: tb/tb_main_memory_burst.sv
// Self-checking bench for main_memory_burst: timing of every beat, read data against a
// word-level memory model, write-back, wrap order, pending slot, proto_err, reset mid-burst
// and first-beat latency for LATENCY = 1, 4, 10.
module tb_main_memory_burst;
    import mem_if_pkg::*;

    localparam int LAT = 4;

    logic clk;
    logic rst_n;
    logic addrstb;
    logic we;
    logic [31:0] addr;
    logic tb_drv;
    logic [63:0] tb_data;

    wire [63:0] bus;
    wire [63:0] bus_l1;
    wire [63:0] bus_l10;

    logic stb, busy, perr;
    logic stb_l1, busy_l1, perr_l1;
    logic stb_l10, busy_l10, perr_l10;

    int n_checks;
    int n_errors;

    logic [63:0] mem_m [4096];
    bit          mem_v [4096];
    logic [63:0] wr_data [8];
    logic        exp_stb;
    logic        exp_perr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus = tb_drv ? tb_data : 64'bz;

    // Undriven bus reads all ones, which makes a released bus observable.
    for (genvar i = 0; i < 64; i++) begin : g_pull
        pullup (bus[i]);
        pullup (bus_l1[i]);
        pullup (bus_l10[i]);
    end

    main_memory_burst #(.MEM_DEPTH_LOG2(12), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .addrstb_MEM(addrstb), .we_MEM(we), .addr_MEM(addr),
        .data_MEM(bus), .stb(stb), .busy(busy), .proto_err(perr)
    );

    main_memory_burst #(.MEM_DEPTH_LOG2(12), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .addrstb_MEM(addrstb), .we_MEM(we), .addr_MEM(addr),
        .data_MEM(bus_l1), .stb(stb_l1), .busy(busy_l1), .proto_err(perr_l1)
    );

    main_memory_burst #(.MEM_DEPTH_LOG2(12), .LATENCY(10)) dut_l10 (
        .clk(clk), .rst_n(rst_n), .addrstb_MEM(addrstb), .we_MEM(we), .addr_MEM(addr),
        .data_MEM(bus_l10), .stb(stb_l10), .busy(busy_l10), .proto_err(perr_l10)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word touched by beat k of a burst starting at byte address a.
    function automatic int beat_word(input logic [31:0] a, input int k);
        int idx;
        idx = int'(a[14:3]);
        return (idx & ~7) | ((idx + k) % 8);
    endfunction

    task automatic req_toggle(input logic rd, input logic [31:0] a);
        we      = rd;
        addr    = a;
        addrstb = ~addrstb;
    endtask

    // Cycle c = sample after the c-th posedge following toggle detect.
    // Beat k edge is c = LAT+1+2k; busy ends at c = LAT+16.
    task automatic run_burst(input logic rd, input logic [31:0] a, input bit fresh,
                             input int inj1, input logic [31:0] inj_a1,
                             input int inj2, input logic [31:0] inj_a2,
                             input int abort_c);
        int  nt;
        int  w;
        int  k;
        int  last;
        bit  pend;
        pend = 1'b0;
        last = LAT + 16;
        if (fresh) req_toggle(rd, a);
        for (int c = (fresh ? 0 : 1); c <= last; c++) begin
            @(negedge clk);
            nt = (c >= LAT + 1) ? ((c - LAT - 1) / 2 + 1) : 0;
            if (nt > 8) nt = 8;
            check_eq("stb", 64'(stb), 64'(exp_stb ^ nt[0]));
            check_eq("busy", 64'(busy), 64'((c <= LAT + 15) || pend));
            check_eq("proto_err", 64'(perr), 64'(exp_perr));
            if (rd && nt > 0 && c < last) begin
                w = beat_word(a, nt - 1);
                if (mem_v[w]) check_eq("rd_data", bus, mem_m[w]);
            end else if (!tb_drv) begin
                check_eq("bus_z", bus, {64{1'b1}});
            end

            if (c == abort_c) begin
                rst_n   = 1'b0;
                addrstb = 1'b0;
                #1;
                check_eq("rst_stb", 64'(stb), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_perr", 64'(perr), 64'd0);
                check_eq("rst_bus_z", bus, {64{1'b1}});
                exp_stb  = 1'b0;
                exp_perr = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            if (!rd) begin
                if (c >= LAT && c <= LAT + 14 && ((c - LAT) % 2) == 0) begin
                    k          = (c - LAT) / 2;
                    tb_data    = wr_data[k];
                    tb_drv     = 1'b1;
                    w          = beat_word(a, k);
                    mem_m[w]   = wr_data[k];
                    mem_v[w]   = 1'b1;
                end else begin
                    tb_drv = 1'b0;
                end
            end
            if (c == inj1) begin
                req_toggle(1'b1, inj_a1);
                pend = 1'b1;
            end
            if (c == inj2) begin
                req_toggle(1'b1, inj_a2);
                exp_perr = 1'b1;
            end
        end
    endtask

    initial begin
        int f0, f1, f10;
        logic rd;
        logic [31:0] a;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        addrstb  = 1'b0;
        we       = 1'b1;
        addr     = '0;
        tb_drv   = 1'b0;
        tb_data  = '0;
        exp_stb  = 1'b0;
        exp_perr = 1'b0;
        for (int i = 0; i < 4096; i++) mem_v[i] = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_stb", 64'(stb), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_perr", 64'(perr), 64'd0);
        check_eq("reset_bus_z", bus, {64{1'b1}});
        rst_n = 1'b1;
        @(negedge clk);

        // First-beat latency for all three instances from one shared request.
        f0 = -1; f1 = -1; f10 = -1;
        req_toggle(1'b1, 32'h200);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (f0 < 0 && stb != 1'b0) f0 = c;
            if (f1 < 0 && stb_l1 != 1'b0) f1 = c;
            if (f10 < 0 && stb_l10 != 1'b0) f10 = c;
        end
        check_eq("first_beat_lat4", 64'(f0), 64'(LAT + 1));
        check_eq("first_beat_lat1", 64'(f1), 64'd2);
        check_eq("first_beat_lat10", 64'(f10), 64'd11);
        check_eq("idle_lat1", 64'({busy_l1, perr_l1, stb_l1}), 64'd0);
        check_eq("idle_lat10", 64'({busy_l10, perr_l10, stb_l10}), 64'd0);
        check_eq("idle_lat4", 64'(busy), 64'd0);

        // Preload words 0x40..0x47 with 0..7, then write-back 0xA0..0xA7 at 0x400.
        for (int i = 0; i < 8; i++) wr_data[i] = 64'(i);
        run_burst(1'b0, 32'h200, 1'b1, -1, 0, -1, 0, -1);
        for (int i = 0; i < 8; i++) wr_data[i] = 64'hA0 + 64'(i);
        run_burst(1'b0, 32'h400, 1'b1, -1, 0, -1, 0, -1);

        // Fill 0x200, second request (wrap at 0x228) during beat 3, third one dropped.
        run_burst(1'b1, 32'h200, 1'b1, LAT + 7, 32'h228, LAT + 10, 32'h400, -1);
        run_burst(1'b1, 32'h228, 1'b0, -1, 0, -1, 0, -1);
        repeat (4) begin
            @(negedge clk);
            check_eq("dropped_busy", 64'(busy), 64'd0);
            check_eq("dropped_stb", 64'(stb), 64'(exp_stb));
        end

        run_burst(1'b1, 32'h400, 1'b1, -1, 0, -1, 0, -1);

        // Random traffic over a few lines with random high (aliased) address bits.
        for (int n = 0; n < 10; n++) begin
            rd        = 1'($urandom_range(0, 1));
            a         = $urandom;
            a[14:6]   = 9'($urandom_range(8, 11));
            for (int i = 0; i < 8; i++) wr_data[i] = {$urandom, $urandom};
            run_burst(rd, a, 1'b1, -1, 0, -1, 0, -1);
        end

        // Reset at beat 4, then a normal fill.
        run_burst(1'b1, 32'h200, 1'b1, -1, 0, -1, 0, LAT + 9);
        run_burst(1'b1, 32'h200, 1'b1, -1, 0, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
